// File: rtl/calc_alu_sequencer_if.sv
// calc_alu_sequencer_if: request/result bundle between a requester (master)
// and the sequencing ALU (slave).
`default_nettype none

interface calc_alu_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH:0]   C;
   logic [WIDTH-1:0] R;
   logic             Busy;
   logic             Done;
   logic             Flag;
   logic [6:0]       State;

   modport master (
      output Start, Op, A, B,
      input  C, R, Busy, Done, Flag, State
   );

   modport slave (
      input  Start, Op, A, B,
      output C, R, Busy, Done, Flag, State
   );
endinterface

`default_nettype wire

// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: one-hot sequenced add/sub/mul/div unit with sticky status.
// Macro CALC_MULDIV_EN builds the shift-add multiplier and restoring divider.
`default_nettype none

module calc_alu_sequencer #(
   parameter int WIDTH = 16
) (
   input wire                  board_clk,
   input wire                  Reset,
   calc_alu_sequencer_if.slave alu_if
);

   typedef enum logic [6:0] {
      S_IDLE = 7'b0000001,
      S_ADD  = 7'b0000010,
      S_SUB  = 7'b0000100,
      S_MUL  = 7'b0001000,
      S_DIV  = 7'b0010000,
      S_ERR  = 7'b0100000,
      S_DONE = 7'b1000000
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   c_q;
   logic [WIDTH-1:0] r_q;
   logic             flag_q;
   logic             done_q;

`ifdef CALC_MULDIV_EN
   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;

   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH:0]     rem_shift_d;
   logic [WIDTH:0]     rem_diff_d;
   logic               div_ge_d;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   quo_d;

   // The partial remainder is always below 2*B, so the diff sign bit is exact.
   always_comb begin
      prod_d      = prod_q + (b_q[0] ? mcand_q : '0);
      rem_shift_d = {rem_q, quo_q[WIDTH-1]};
      rem_diff_d  = rem_shift_d - {1'b0, b_q};
      div_ge_d    = ~rem_diff_d[WIDTH];
      rem_d       = div_ge_d ? rem_diff_d[WIDTH-1:0] : rem_shift_d[WIDTH-1:0];
      quo_d       = {quo_q[WIDTH-2:0], div_ge_d};
   end
`endif

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         r_q     <= '0;
         flag_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef CALC_MULDIV_EN
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (alu_if.Start) begin
                  a_q    <= alu_if.A;
                  b_q    <= alu_if.B;
                  c_q    <= '0;
                  r_q    <= '0;
                  flag_q <= 1'b0;
`ifdef CALC_MULDIV_EN
                  cnt_q   <= '0;
                  prod_q  <= '0;
                  mcand_q <= {{WIDTH{1'b0}}, alu_if.A};
                  rem_q   <= '0;
                  quo_q   <= alu_if.A;
`endif
                  unique case (alu_if.Op)
                     2'b00:   state_q <= S_ADD;
                     2'b01:   state_q <= S_SUB;
`ifdef CALC_MULDIV_EN
                     2'b10:   state_q <= S_MUL;
                     default: state_q <= (alu_if.B == '0) ? S_ERR : S_DIV;
`else
                     default: state_q <= S_ERR;
`endif
                  endcase
               end
            end
            S_ADD: begin
               c_q     <= {1'b0, a_q} + {1'b0, b_q};
               flag_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_SUB: begin
               c_q     <= {1'b0, a_q} - {1'b0, b_q};
               flag_q  <= (a_q < b_q);
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
`ifdef CALC_MULDIV_EN
            S_MUL: begin
               prod_q  <= prod_d;
               mcand_q <= mcand_q << 1;
               b_q     <= b_q >> 1;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) begin
                  c_q     <= prod_d[WIDTH:0];
                  flag_q  <= |prod_d[2*WIDTH-1:WIDTH+1];
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) begin
                  c_q     <= {1'b0, quo_d};
                  r_q     <= rem_d;
                  flag_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
`endif
            S_ERR: begin
               c_q     <= '1;
               r_q     <= '0;
               flag_q  <= 1'b1;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign alu_if.C     = c_q;
   assign alu_if.R     = r_q;
   assign alu_if.Flag  = flag_q;
   assign alu_if.Done  = done_q;
   assign alu_if.Busy  = ~state_q[0];
   assign alu_if.State = state_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_alu_sequencer.sv
// tb_calc_alu_sequencer: directed self-checking bench for calc_alu_sequencer.
// Start is driven on falling edges; outputs are sampled on falling edges.
`default_nettype none

module tb_calc_alu_sequencer;
   localparam int W = 16;
   localparam logic [6:0] ST_IDLE = 7'h01;
   localparam logic [6:0] ST_ADD  = 7'h02;
   localparam logic [6:0] ST_SUB  = 7'h04;
   localparam logic [6:0] ST_ERR  = 7'h20;
   localparam logic [6:0] ST_DONE = 7'h40;
`ifdef CALC_MULDIV_EN
   localparam logic [6:0] ST_MUL  = 7'h08;
   localparam logic [6:0] ST_DIV  = 7'h10;
`endif

   logic board_clk = 1'b0;
   logic Reset;
   int   checks   = 0;
   int   failures = 0;
   int   n;

   calc_alu_sequencer_if #(.WIDTH(W)) alu_if ();

   calc_alu_sequencer #(.WIDTH(W)) dut (
      .board_clk (board_clk),
      .Reset     (Reset),
      .alu_if    (alu_if)
   );

   always #5 board_clk = ~board_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns at the falling edge after acceptance.
   task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      @(negedge board_clk);
      alu_if.A     = a;
      alu_if.B     = b;
      alu_if.Op    = op;
      alu_if.Start = 1'b1;
      @(negedge board_clk);
      alu_if.Start = 1'b0;
      alu_if.A     = 16'hA5A5;
      alu_if.B     = 16'h5A5A;
      alu_if.Op    = ~op;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (alu_if.Done !== 1'b1 && cycles < 64) begin
         @(negedge board_clk);
         cycles++;
      end
   endtask

   initial begin
      Reset        = 1'b1;
      alu_if.Start = 1'b0;
      alu_if.Op    = 2'b00;
      alu_if.A     = '0;
      alu_if.B     = '0;
      repeat (2) @(negedge board_clk);
      chk("reset_state", 32'(alu_if.State), 32'(ST_IDLE));
      chk("reset_busy",  32'(alu_if.Busy), 32'd0);
      chk("reset_done",  32'(alu_if.Done), 32'd0);
      chk("reset_c",     32'(alu_if.C), 32'd0);
      chk("reset_flag",  32'(alu_if.Flag), 32'd0);
      Reset = 1'b0;

      // Add with carry out; operand changes after latch must not matter.
      do_start(16'hFFFF, 16'h0001, 2'b00);
      chk("add_state", 32'(alu_if.State), 32'(ST_ADD));
      chk("add_busy1", 32'(alu_if.Busy), 32'd1);
      chk("add_done0", 32'(alu_if.Done), 32'd0);
      @(negedge board_clk);
      chk("add_done1", 32'(alu_if.Done), 32'd1);
      chk("add_busy2", 32'(alu_if.Busy), 32'd1);
      chk("add_dstate", 32'(alu_if.State), 32'(ST_DONE));
      chk("add_c",     32'(alu_if.C), 32'h10000);
      chk("add_flag",  32'(alu_if.Flag), 32'd0);
      @(negedge board_clk);
      chk("add_idle_busy", 32'(alu_if.Busy), 32'd0);
      chk("add_idle_done", 32'(alu_if.Done), 32'd0);
      chk("add_hold_c",    32'(alu_if.C), 32'h10000);

      // Sub with borrow; Start during SUB and during DONE is ignored.
      do_start(16'h0003, 16'h0005, 2'b01);
      chk("sub_clear_c", 32'(alu_if.C), 32'd0);
      chk("sub_state",   32'(alu_if.State), 32'(ST_SUB));
      alu_if.Start = 1'b1;
      alu_if.Op    = 2'b00;
      @(negedge board_clk);
      chk("sub_done", 32'(alu_if.Done), 32'd1);
      chk("sub_c",    32'(alu_if.C), 32'h1FFFE);
      chk("sub_flag", 32'(alu_if.Flag), 32'd1);
      @(negedge board_clk);
      alu_if.Start = 1'b0;
      chk("sub_ign_state", 32'(alu_if.State), 32'(ST_IDLE));
      chk("sub_hold_c",    32'(alu_if.C), 32'h1FFFE);
      chk("sub_hold_flag", 32'(alu_if.Flag), 32'd1);

      // Plain add; sticky flag cleared on acceptance.
      do_start(16'h1234, 16'h4321, 2'b00);
      chk("add2_flag_clr", 32'(alu_if.Flag), 32'd0);
      wait_done(n);
      chk("add2_lat", 32'(n), 32'd1);
      chk("add2_c",   32'(alu_if.C), 32'h05555);

      // Sub boundaries: A>B and A==B.
      do_start(16'h0005, 16'h0003, 2'b01);
      wait_done(n);
      chk("sub2_c",    32'(alu_if.C), 32'h00002);
      chk("sub2_flag", 32'(alu_if.Flag), 32'd0);
      do_start(16'h0007, 16'h0007, 2'b01);
      wait_done(n);
      chk("sub3_c",    32'(alu_if.C), 32'h00000);
      chk("sub3_flag", 32'(alu_if.Flag), 32'd0);

      // Divide by zero always errors.
      do_start(16'h0064, 16'h0000, 2'b11);
      chk("div0_state", 32'(alu_if.State), 32'(ST_ERR));
      wait_done(n);
      chk("div0_lat",  32'(n), 32'd1);
      chk("div0_c",    32'(alu_if.C), 32'h1FFFF);
      chk("div0_r",    32'(alu_if.R), 32'd0);
      chk("div0_flag", 32'(alu_if.Flag), 32'd1);

`ifdef CALC_MULDIV_EN
      do_start(16'h0100, 16'h0300, 2'b10);
      chk("mul_state", 32'(alu_if.State), 32'(ST_MUL));
      chk("mul_clr_c", 32'(alu_if.C), 32'd0);
      repeat (3) @(negedge board_clk);
      alu_if.Start = 1'b1;
      alu_if.A     = 16'h0001;
      alu_if.B     = 16'h0001;
      alu_if.Op    = 2'b00;
      @(negedge board_clk);
      alu_if.Start = 1'b0;
      chk("mul_ign_state", 32'(alu_if.State), 32'(ST_MUL));
      wait_done(n);
      chk("mul_lat",  32'(n), 32'd12);
      chk("mul_c",    32'(alu_if.C), 32'h10000);
      chk("mul_flag", 32'(alu_if.Flag), 32'd1);

      do_start(16'h00FF, 16'h0101, 2'b10);
      wait_done(n);
      chk("mul2_lat",  32'(n), 32'd16);
      chk("mul2_c",    32'(alu_if.C), 32'h0FFFF);
      chk("mul2_flag", 32'(alu_if.Flag), 32'd0);

      // Asynchronous reset in the middle of a divide.
      do_start(16'h0064, 16'h0007, 2'b11);
      chk("div_state", 32'(alu_if.State), 32'(ST_DIV));
      repeat (8) @(negedge board_clk);
      #2 Reset = 1'b1;
      #1;
      chk("divrst_state", 32'(alu_if.State), 32'(ST_IDLE));
      chk("divrst_busy",  32'(alu_if.Busy), 32'd0);
      chk("divrst_c",     32'(alu_if.C), 32'd0);
      repeat (3) @(negedge board_clk);
      chk("divrst_done", 32'(alu_if.Done), 32'd0);
      Reset = 1'b0;

      do_start(16'h0064, 16'h0007, 2'b11);
      wait_done(n);
      chk("div_lat",  32'(n), 32'd16);
      chk("div_c",    32'(alu_if.C), 32'h0000E);
      chk("div_r",    32'(alu_if.R), 32'h0002);
      chk("div_flag", 32'(alu_if.Flag), 32'd0);
`else
      // Without the multiplier/divider both ops are errors.
      do_start(16'h0005, 16'h0003, 2'b10);
      chk("mul_err_state", 32'(alu_if.State), 32'(ST_ERR));
      wait_done(n);
      chk("mul_err_lat",  32'(n), 32'd1);
      chk("mul_err_c",    32'(alu_if.C), 32'h1FFFF);
      chk("mul_err_flag", 32'(alu_if.Flag), 32'd1);
      do_start(16'h0064, 16'h0007, 2'b11);
      wait_done(n);
      chk("div_err_lat", 32'(n), 32'd1);
      chk("div_err_c",   32'(alu_if.C), 32'h1FFFF);
      chk("div_err_r",   32'(alu_if.R), 32'd0);

      // Asynchronous reset in the middle of an add.
      do_start(16'h0001, 16'h0002, 2'b00);
      #2 Reset = 1'b1;
      #1;
      chk("addrst_state", 32'(alu_if.State), 32'(ST_IDLE));
      chk("addrst_busy",  32'(alu_if.Busy), 32'd0);
      repeat (2) @(negedge board_clk);
      chk("addrst_done", 32'(alu_if.Done), 32'd0);
      chk("addrst_flag", 32'(alu_if.Flag), 32'd0);
      Reset = 1'b0;
`endif

      do_start(16'h8000, 16'h8000, 2'b00);
      wait_done(n);
      chk("post_rst_lat", 32'(n), 32'd1);
      chk("post_rst_c",   32'(alu_if.C), 32'h10000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
